// File: rtl/lzc_2bit_aligned_big_endian_pkg.sv
// ---------------------------------------------------------------------------
// Package lzc_pkg
//   Shared constants and width helpers for the 2-bit-aligned leading-zero
//   counter (lzc_2bit_aligned_big_endian) and its pair cells.
//   LEAF_W    : bits examined per tree leaf
//   lzc_cnt_w : width of the count output for a given operand width
//   pad_w     : operand width rounded up to a whole number of leaves
// ---------------------------------------------------------------------------
package lzc_pkg;

    localparam int LEAF_W = 2;

    function automatic int lzc_cnt_w(input int width);
        return $clog2(width);
    endfunction

    function automatic int pad_w(input int width);
        return width + (width % LEAF_W);
    endfunction

endpackage

// File: rtl/lzc_2bit_aligned_big_endian_if.sv
// ---------------------------------------------------------------------------
// Interface lzc_2bit_aligned_big_endian_if
//   Operand/result bundle of the leading-zero counter.
//   b : operand to scan, MSB = bit WIDTH-1        (master -> slave)
//   p : leading-zero count, $clog2(WIDTH) bits     (slave -> master)
//   v : 1 = operand had at least one set bit       (slave -> master)
//   modport master : the block supplying operands (normaliser front end)
//   modport slave  : the counter itself
// ---------------------------------------------------------------------------
interface lzc_2bit_aligned_big_endian_if
    import lzc_pkg::*;
#(
    parameter int WIDTH = 28
);

    logic [WIDTH-1:0]            b;
    logic [lzc_cnt_w(WIDTH)-1:0] p;
    logic                        v;

    modport master (output b, input p, input v);
    modport slave  (input b, output p, output v);

endinterface

// File: rtl/lzc_2bit_aligned_big_endian_pair_cell.sv
// ---------------------------------------------------------------------------
// Module lzc_pair_cell
//   Leaf of the leading-zero tree: inspects one 2-bit group of the operand.
//   pair    : the two bits, pair[1] is the more significant one
//   zero    : 1 = both bits are 0, the count continues past this group
//   hi_zero : (LZC_EXACT_EN only) 1 = upper bit is 0, so if the group is
//             non-zero its lower bit is the first 1 and adds one to the count
// Optional feature macro: LZC_EXACT_EN
// ---------------------------------------------------------------------------
module lzc_pair_cell
    import lzc_pkg::*;
(
    input  logic [LEAF_W-1:0] pair,
    output logic              zero
`ifdef LZC_EXACT_EN
    ,
    output logic              hi_zero
`endif
);

    assign zero = ~|pair;

`ifdef LZC_EXACT_EN
    assign hi_zero = ~pair[LEAF_W-1];
`endif

endmodule

// File: rtl/lzc_2bit_aligned_big_endian.sv
// ---------------------------------------------------------------------------
// Module lzc_2bit_aligned_big_endian
//   Registered leading-zero counter for the approximate-FP normalisation
//   path. Zeros are counted from bit WIDTH-1 downward in whole 2-bit groups,
//   so the default count is rounded down to an even value. One cycle of
//   latency, a new operand every cycle, no handshake.
//
//   Parameters
//     WIDTH  operand width (>= 2); odd widths get one 0 appended below LSB
//   Ports
//     clk    clock, all state on the rising edge
//     rst_n  asynchronous active-low reset, clears p and v
//     bus    lzc_2bit_aligned_big_endian_if.slave  (b in, p/v out)
//
//   Optional feature macro: LZC_EXACT_EN
//     defined   : p is the exact leading-zero count (p[0] may be 1)
//     undefined : p = 2*floor(lz/2), leaf lower-bit logic is not built
// ---------------------------------------------------------------------------
module lzc_2bit_aligned_big_endian
    import lzc_pkg::*;
#(
    parameter int WIDTH = 28
)(
    input  logic                           clk,
    input  logic                           rst_n,
    lzc_2bit_aligned_big_endian_if.slave   bus
);

    localparam int P_W   = lzc_cnt_w(WIDTH);
    localparam int PW    = pad_w(WIDTH);
    localparam int NP    = PW / LEAF_W;               // real leaves
    localparam int NP2   = 2 ** $clog2(NP);           // leaves rounded to a full tree
    localparam int NODES = 2 * NP2 - 1;               // heap: root 0, children 2i+1 / 2i+2

    logic [PW-1:0]  b_pad;
    logic           z_node [NODES];                   // subtree is all zero
    logic [P_W-1:0] c_node [NODES];                   // zeros before first 1 in subtree
    logic [P_W-1:0] p_d;
    logic           v_d;
    logic [P_W-1:0] p_q;
    logic           v_q;

    generate
        if (WIDTH % LEAF_W != 0) begin : g_pad
            assign b_pad = {bus.b, 1'b0};
        end else begin : g_nopad
            assign b_pad = bus.b;
        end
    endgenerate

    // Leaves: leaf j covers pair j counted from the MSB side, so the heap's
    // left-to-right leaf order matches significance.
    generate
        for (genvar j = 0; j < NP2; j++) begin : g_leaf
            localparam int NODE = NP2 - 1 + j;
            if (j < NP) begin : g_cell
                logic cell_zero;
`ifdef LZC_EXACT_EN
                logic cell_hi_zero;
                lzc_pair_cell u_cell (
                    .pair    (b_pad[PW-1-LEAF_W*j -: LEAF_W]),
                    .zero    (cell_zero),
                    .hi_zero (cell_hi_zero)
                );
                assign c_node[NODE] = P_W'(cell_hi_zero);
`else
                lzc_pair_cell u_cell (
                    .pair (b_pad[PW-1-LEAF_W*j -: LEAF_W]),
                    .zero (cell_zero)
                );
                assign c_node[NODE] = '0;
`endif
                assign z_node[NODE] = cell_zero;
            end else begin : g_fill
                // Filler leaves sit below the LSB; they only matter when the
                // whole operand is zero, where p is forced to 0 anyway.
                assign z_node[NODE] = 1'b1;
                assign c_node[NODE] = '0;
            end
        end
    endgenerate

    // Priority merge: the MSB-side (left) child wins unless it is all zero,
    // in which case its full bit span is added to the right child's count.
    // Arithmetic is modulo 2**P_W; every count that reaches p fits exactly.
    generate
        for (genvar i = 0; i < NP2 - 1; i++) begin : g_merge
            localparam int DEPTH  = $clog2(i + 2) - 1;
            localparam int SPAN   = LEAF_W * (NP2 >> (DEPTH + 1));
            localparam logic [P_W-1:0] SPAN_C = P_W'(SPAN);
            assign z_node[i] = z_node[2*i+1] & z_node[2*i+2];
            assign c_node[i] = z_node[2*i+1] ? SPAN_C + c_node[2*i+2]
                                             : c_node[2*i+1];
        end
    endgenerate

    assign v_d = ~z_node[0];
    assign p_d = z_node[0] ? '0 : c_node[0];

    // NOTE: registers use non-blocking assignments and an async clear so p/v
    // drop the moment rst_n falls, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
            v_q <= 1'b0;
        end else begin
            p_q <= p_d;
            v_q <= v_d;
        end
    end

    assign bus.p = p_q;
    assign bus.v = v_q;

endmodule

// File: tb/tb_lzc_2bit_aligned_big_endian.sv
// ---------------------------------------------------------------------------
// Testbench tb_lzc_2bit_aligned_big_endian
//   Drives WIDTH=28, WIDTH=7 and WIDTH=2 instances of the counter with a
//   directed vector table, reset sequences and random operands compared
//   against a bit-scanning reference model. Honours LZC_EXACT_EN.
// ---------------------------------------------------------------------------
module tb_lzc_2bit_aligned_big_endian;

`ifdef LZC_EXACT_EN
    localparam bit EXACT = 1'b1;
`else
    localparam bit EXACT = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;

    lzc_2bit_aligned_big_endian_if #(.WIDTH(28)) if28 ();
    lzc_2bit_aligned_big_endian_if #(.WIDTH(7))  if7  ();
    lzc_2bit_aligned_big_endian_if #(.WIDTH(2))  if2  ();

    lzc_2bit_aligned_big_endian #(.WIDTH(28)) dut28 (.clk(clk), .rst_n(rst_n), .bus(if28.slave));
    lzc_2bit_aligned_big_endian #(.WIDTH(7))  dut7  (.clk(clk), .rst_n(rst_n), .bus(if7.slave));
    lzc_2bit_aligned_big_endian #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] b;
        int          p_apx;
        int          p_exa;
        logic        v;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: scan from the top bit down and count zeros, then round.
    function automatic int model_p(input logic [31:0] x, input int w);
        int lz;
        lz = 0;
        for (int k = w - 1; k >= 0; k--) begin
            if (x[k]) break;
            lz++;
        end
        if (lz == w) return 0;
        return EXACT ? lz : (lz / 2) * 2;
    endfunction

    function automatic logic model_v(input logic [31:0] x);
        return x != 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_p28"}, 32'(if28.p), 32'(model_p(32'(if28.b), 28)));
        check({tag, "_v28"}, 32'(if28.v), 32'(model_v(32'(if28.b))));
        check({tag, "_p7"},  32'(if7.p),  32'(model_p(32'(if7.b), 7)));
        check({tag, "_v7"},  32'(if7.v),  32'(model_v(32'(if7.b))));
        check({tag, "_p2"},  32'(if2.p),  32'(model_p(32'(if2.b), 2)));
        check({tag, "_v2"},  32'(if2.v),  32'(model_v(32'(if2.b))));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        tbl[0]  = '{28'hFFFFFAA, 0,  0,  1'b1};
        tbl[1]  = '{28'hFFFFFAC, 0,  0,  1'b1};
        tbl[2]  = '{28'hFFFFFA8, 0,  0,  1'b1};
        tbl[3]  = '{28'hFFFFFAB, 0,  0,  1'b1};
        tbl[4]  = '{28'h2000000, 2,  2,  1'b1};
        tbl[5]  = '{28'h4000000, 0,  1,  1'b1};
        tbl[6]  = '{28'h8000000, 0,  0,  1'b1};
        tbl[7]  = '{28'h0000001, 26, 27, 1'b1};
        tbl[8]  = '{28'h0000000, 0,  0,  1'b0};
        tbl[9]  = '{28'h0000002, 26, 26, 1'b1};
        tbl[10] = '{28'h0100000, 6,  7,  1'b1};
        tbl[11] = '{28'h0080000, 8,  8,  1'b1};

        // Reset holds outputs low even with a non-zero operand present.
        rst_n  = 1'b0;
        if28.b = 28'h0000001;
        if7.b  = 7'h01;
        if2.b  = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        check("rst_p28", 32'(if28.p), 32'd0);
        check("rst_v28", 32'(if28.v), 32'd0);
        check("rst_p7",  32'(if7.p),  32'd0);
        check("rst_v7",  32'(if7.v),  32'd0);
        check("rst_p2",  32'(if2.p),  32'd0);
        check("rst_v2",  32'(if2.v),  32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_p28", 32'(if28.p), EXACT ? 32'd27 : 32'd26);
        check("first_v28", 32'(if28.v), 32'd1);
        check("first_p7",  32'(if7.p),  EXACT ? 32'd6 : 32'd6);
        check("first_p2",  32'(if2.p),  EXACT ? 32'd1 : 32'd0);

        // Directed table, one vector per cycle.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if28.b = tbl[i].b;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_p", i), 32'(if28.p), 32'(EXACT ? tbl[i].p_exa : tbl[i].p_apx));
            check($sformatf("tbl%0d_v", i), 32'(if28.v), 32'(tbl[i].v));
        end

        // Output holds its value until the next edge even if b changes.
        @(negedge clk);
        if28.b = 28'h0000001;
        @(posedge clk);
        #1;
        if28.b = 28'h8000000;
        #3;
        check("hold_p", 32'(if28.p), EXACT ? 32'd27 : 32'd26);

        // Reset pulse of half a cycle mid-stream.
        @(negedge clk);
        if28.b = 28'h0000001;
        @(posedge clk);
        #1;
        check("pre_pulse_p", 32'(if28.p), EXACT ? 32'd27 : 32'd26);
        #1;
        rst_n = 1'b0;
        #1;
        check("pulse_p", 32'(if28.p), 32'd0);
        check("pulse_v", 32'(if28.v), 32'd0);
        if28.b = 28'h2000000;
        #4;
        rst_n = 1'b1;
        check("pulse_hold_v", 32'(if28.v), 32'd0);
        @(posedge clk);
        #1;
        check("resume_p", 32'(if28.p), 32'd2);
        check("resume_v", 32'(if28.v), 32'd1);

        // Random operands with a spread of leading-zero counts.
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            if28.b = 28'($urandom >> $urandom_range(0, 32));
            if7.b  = 7'($urandom >> $urandom_range(25, 32));
            if2.b  = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
